// File: rtl/uart_pkg.sv
//==============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the uart_tx arbiter and uart_tx.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        SEND_S = 2'd1,
        GAP_S  = 2'd2
    } state_t;

    // Frame shape shared with uart_tx: Manchester sends two half-bit symbols per bit.
    localparam int UART_DATA_BITS     = 8;
    localparam int UART_START_BITS    = 1;
    localparam int UART_STOP_BITS     = 1;
    localparam int UART_HALVES_PER_BIT = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//==============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick; search starts just after ptr.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N = 4,
    parameter int W = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt_onehot,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    logic [W-1:0] cand;

    always_comb begin
        any     = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = W'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any     = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt_onehot = any ? (N'(1) << gnt_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
//==============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin sharing of one uart_tx among NUM_REQ byte sources,
//               with post-frame gap and a send watchdog.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_BITS      = 8,
    parameter int GAP_CYCLES     = 162,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int SRC_W         = clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_valid,
    output logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_ready,
    output logic [SRC_W-1:0]             cur_src,
    output logic                         busy,
    output logic                         drop
);

    localparam logic [31:0] GAP_LOAD  = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [SRC_W-1:0]     cur_src_q, cur_src_d;
    logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [31:0]          gap_q, gap_d;
    logic [31:0]          wdog_q, wdog_d;

    logic [NUM_REQ-1:0]   gnt_onehot;
    logic [SRC_W-1:0]     gnt_idx;
    logic                 gnt_any;
    logic [NUM_REQ-1:0]   ready_c;
    logic                 drop_c;
    logic [DATA_BITS-1:0] req_bytes [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_bytes[i] = req_data[i*DATA_BITS +: DATA_BITS];
    end

    rr_arbiter #(
        .N (NUM_REQ),
        .W (SRC_W)
    ) u_rr (
        .req        (req_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cur_src_d = cur_src_q;
        rr_ptr_d  = rr_ptr_q;
        gap_d     = gap_q;
        wdog_d    = wdog_q;
        ready_c   = '0;
        drop_c    = 1'b0;
        case (state_q)
            IDLE_S: begin
                ready_c = gnt_onehot;
                if (gnt_any) begin
                    data_d    = req_bytes[gnt_idx];
                    cur_src_d = gnt_idx;
                    rr_ptr_d  = gnt_idx;
                    wdog_d    = '0;
                    state_d   = SEND_S;
                end
            end
            SEND_S: begin
                wdog_d = wdog_q + 32'd1;
                // A handshake on the timeout cycle still counts as delivered.
                if (tx_ready || (TIMEOUT_CYCLES != 0 && wdog_q == WDOG_LAST)) begin
                    drop_c = !tx_ready;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE_S;
                    end else begin
                        state_d = GAP_S;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            GAP_S: begin
                if (gap_q == 32'd0) begin
                    state_d = IDLE_S;
                end else begin
                    gap_d = gap_q - 32'd1;
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE_S;
            data_q    <= '0;
            cur_src_q <= '0;
            rr_ptr_q  <= SRC_W'(NUM_REQ - 1);
            gap_q     <= '0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            cur_src_q <= cur_src_d;
            rr_ptr_q  <= rr_ptr_d;
            gap_q     <= gap_d;
            wdog_q    <= wdog_d;
        end
    end

    // Outputs are masked by reset so a mid-frame reset drops tx_valid immediately.
    assign req_ready = reset ? '0 : ready_c;
    assign tx_valid  = !reset && (state_q == SEND_S);
    assign tx_data   = reset ? '0 : data_q;
    assign cur_src   = reset ? '0 : cur_src_q;
    assign busy      = !reset && (state_q != IDLE_S);
    assign drop      = !reset && drop_c;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//==============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter with a uart_tx stand-in.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int DB  = 8;
    localparam int GAP = 4;
    localparam int TMO = 50;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*DB-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic            tx_valid;
    logic [DB-1:0]   tx_data;
    logic            tx_ready = 1'b0;
    logic [1:0]      cur_src;
    logic            busy;
    logic            drop;

    uart_tx_arbiter #(
        .NUM_REQ        (NR),
        .DATA_BITS      (DB),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .cur_src   (cur_src),
        .busy      (busy),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_wait(input string name);
        n_total++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Producers: one byte queue per requester, presented with ready/valid.
    logic [7:0]    pq [NR][$];
    logic [NR-1:0] p_cap;

    always begin
        @(posedge clk);
        p_cap = req_ready;
        #1;
        for (int i = 0; i < NR; i++) begin
            if (p_cap[i] && pq[i].size() != 0) void'(pq[i].pop_front());
            req_valid[i] = (pq[i].size() != 0);
            req_data[i*DB +: DB] = (pq[i].size() != 0) ? pq[i][0] : 8'h00;
        end
    end

    // uart_tx stand-in: raises tx_ready after a programmable number of valid cycles.
    int ready_delay = 0;
    bit never_ready = 1'b0;
    bit rand_mode = 1'b0;
    int u_cnt = 0;
    int u_delay = 0;

    always begin
        @(posedge clk);
        #2;
        if (tx_valid) begin
            if (u_cnt == 0) begin
                if (rand_mode) u_delay = ($urandom_range(0, 9) == 0) ? 60 : int'($urandom_range(0, 6));
                else           u_delay = ready_delay;
            end
            tx_ready = !never_ready && (u_cnt >= u_delay);
            u_cnt++;
        end else begin
            tx_ready = 1'b0;
            u_cnt = 0;
        end
    end

    // Reference model: one outstanding frame at a time, GAP idle cycles after it ends,
    // round-robin winner from the last grant, drop after TMO unanswered send cycles.
    typedef struct { int src; logic [7:0] data; } exp_t;
    exp_t exp_q[$];
    exp_t m_e;
    int   gnt_log[$];
    logic [7:0] uart_log[$];
    int   m_hold = 0, m_send = 0, m_last = NR - 1, m_w = 0;
    int   m_hs = 0, m_drops = 0;
    bit   m_busy, m_drop;

    function automatic int rr_pick(input logic [NR-1:0] v, input int p);
        for (int k = 1; k <= NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_hold = 0;
            m_send = 0;
            m_last = NR - 1;
        end else begin
            m_busy = (exp_q.size() != 0) || (m_hold != 0);
            check("busy", busy, m_busy);
            check("tx_valid", tx_valid, exp_q.size() != 0);
            m_drop = 1'b0;
            if (exp_q.size() != 0) begin
                m_send++;
                check("tx_data", tx_data, exp_q[0].data);
                check("cur_src", cur_src, exp_q[0].src);
                m_drop = !tx_ready && (m_send == TMO);
            end
            check("drop", drop, m_drop);
            if (exp_q.size() != 0 && (tx_ready || m_drop)) begin
                if (tx_ready) begin
                    uart_log.push_back(tx_data);
                    m_hs++;
                end else begin
                    m_drops++;
                end
                void'(exp_q.pop_front());
                m_send = 0;
                m_hold = GAP;
            end else if (m_hold > 0) begin
                m_hold--;
            end
            if (!m_busy && req_valid != 0) begin
                m_w = rr_pick(req_valid, m_last);
                check("req_ready", req_ready, 32'd1 << m_w);
                m_e.src  = m_w;
                m_e.data = req_data[m_w*DB +: DB];
                exp_q.push_back(m_e);
                m_last = m_w;
                gnt_log.push_back(m_w);
            end else begin
                check("req_ready_idle", req_ready, 0);
            end
        end
    end

    function automatic bit drained();
        for (int i = 0; i < NR; i++) if (pq[i].size() != 0) return 1'b0;
        return exp_q.size() == 0 && m_hold == 0 && req_valid == 0;
    endfunction

    task automatic wait_drained(input string name, input int budget);
        int c;
        c = 0;
        while (!drained()) begin
            @(negedge clk);
            c++;
            if (c > budget) begin
                fail_wait(name);
                return;
            end
        end
    endtask

    task automatic wait_tx_valid(input string name, input int budget);
        int c;
        c = 0;
        while (!tx_valid) begin
            @(negedge clk);
            c++;
            if (c > budget) begin
                fail_wait(name);
                return;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Arbitration table: mask pushed at once from idle, expected grant order g0 in [1:0].
    typedef struct packed {
        logic [3:0] mask;
        logic [2:0] n;
        logic [7:0] order;
    } vec_t;
    vec_t vecs [9];
    logic [7:0] t2_exp [5];

    initial begin
        int n, gapc, hs, base, pushed, q;
        bit in_gap;

        vecs[0] = '{mask: 4'b0001, n: 3'd1, order: {2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[1] = '{mask: 4'b1111, n: 3'd4, order: {2'd0, 2'd3, 2'd2, 2'd1}};
        vecs[2] = '{mask: 4'b0101, n: 3'd2, order: {2'd0, 2'd0, 2'd0, 2'd2}};
        vecs[3] = '{mask: 4'b1001, n: 3'd2, order: {2'd0, 2'd0, 2'd0, 2'd3}};
        vecs[4] = '{mask: 4'b0110, n: 3'd2, order: {2'd0, 2'd0, 2'd2, 2'd1}};
        vecs[5] = '{mask: 4'b1011, n: 3'd3, order: {2'd0, 2'd1, 2'd0, 2'd3}};
        vecs[6] = '{mask: 4'b0011, n: 3'd2, order: {2'd0, 2'd0, 2'd1, 2'd0}};
        vecs[7] = '{mask: 4'b1000, n: 3'd1, order: {2'd0, 2'd0, 2'd0, 2'd3}};
        vecs[8] = '{mask: 4'b1110, n: 3'd3, order: {2'd0, 2'd3, 2'd2, 2'd1}};
        t2_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outputs", {req_ready, tx_valid, tx_data, cur_src, busy, drop}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_state", {tx_valid, cur_src, busy, drop}, 0);

        // Table-driven arbitration order, starting from the reset pointer
        for (int v = 0; v < 9; v++) begin
            gnt_log.delete();
            for (int i = 0; i < NR; i++) begin
                if (vecs[v].mask[i]) pq[i].push_back(8'(v * 16 + i));
            end
            wait_drained($sformatf("vec%0d_drain", v), 400);
            check($sformatf("vec%0d_count", v), gnt_log.size(), 32'(vecs[v].n));
            for (int k = 0; k < int'(vecs[v].n) && k < gnt_log.size(); k++) begin
                check($sformatf("vec%0d_g%0d", v, k), gnt_log[k], 32'(vecs[v].order[2*k +: 2]));
            end
        end

        // T1: single byte, latency and gap length
        do_reset(2);
        @(negedge clk);
        pq[0].push_back(8'hA5);
        @(negedge clk);
        check("t1_req_ready", req_ready, 4'b0001);
        @(negedge clk);
        check("t1_ready_off", req_ready, 0);
        check("t1_tx_valid", tx_valid, 1);
        check("t1_tx_data", tx_data, 8'hA5);
        check("t1_cur_src", cur_src, 0);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        check("t1_gap_busy", n, GAP);

        // T2: all four valid, requester 0 has two bytes
        do_reset(2);
        uart_log.delete();
        @(negedge clk);
        pq[0].push_back(8'h10);
        pq[0].push_back(8'h10);
        pq[1].push_back(8'h11);
        pq[2].push_back(8'h12);
        pq[3].push_back(8'h13);
        wait_drained("t2_drain", 400);
        check("t2_count", uart_log.size(), 5);
        for (int k = 0; k < 5 && k < uart_log.size(); k++) begin
            check($sformatf("t2_byte%0d", k), uart_log[k], t2_exp[k]);
        end

        // T3: one requester back-to-back, gap between frames
        @(negedge clk);
        pq[2].push_back(8'h21);
        pq[2].push_back(8'h22);
        pq[2].push_back(8'h23);
        hs = 0; gapc = 0; in_gap = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                hs++;
                in_gap = 1'b1;
                gapc = 0;
            end else if (in_gap && busy && !tx_valid) begin
                gapc++;
            end else if (in_gap) begin
                check($sformatf("t3_gap%0d", hs), gapc, GAP);
                in_gap = 1'b0;
            end
            if (hs == 3 && !in_gap) break;
        end
        check("t3_frames", hs, 3);
        wait_drained("t3_drain", 100);

        // T4: uart never ready -> watchdog drop, then next requester served
        never_ready = 1'b1;
        uart_log.delete();
        gnt_log.delete();
        pq[1].push_back(8'h77);
        pq[2].push_back(8'h88);
        wait_tx_valid("t4_tx_valid", 20);
        n = 0;
        for (int c = 0; c < 80; c++) begin
            if (tx_valid) n++;
            if (drop) break;
            @(negedge clk);
        end
        check("t4_drop_latency", n, TMO);
        check("t4_drop_src", cur_src, 1);
        @(negedge clk);
        check("t4_drop_pulse", {drop, tx_valid}, 0);
        never_ready = 1'b0;
        wait_drained("t4_drain", 200);
        check("t4_sent", uart_log.size(), 1);
        if (uart_log.size() > 0) check("t4_next_byte", uart_log[0], 8'h88);
        check("t4_grants", gnt_log.size(), 2);
        if (gnt_log.size() > 1) check("t4_second_src", gnt_log[1], 2);

        // T5: ready arrives on the watchdog's last cycle -> delivered, no drop
        ready_delay = TMO - 1;
        base = m_drops;
        uart_log.delete();
        pq[3].push_back(8'h5A);
        wait_tx_valid("t5_tx_valid", 20);
        n = 0;
        for (int c = 0; c < 80; c++) begin
            if (tx_valid) n++;
            if (tx_valid && tx_ready) begin
                check("t5_no_drop_same_cycle", drop, 0);
                break;
            end
            @(negedge clk);
        end
        check("t5_valid_cycles", n, TMO);
        wait_drained("t5_drain", 100);
        check("t5_drops", m_drops - base, 0);
        check("t5_sent", uart_log.size(), 1);
        if (uart_log.size() > 0) check("t5_byte", uart_log[0], 8'h5A);
        ready_delay = 0;

        // T6: reset during SEND discards the held byte
        never_ready = 1'b1;
        uart_log.delete();
        pq[1].push_back(8'h3C);
        wait_tx_valid("t6_tx_valid", 20);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("t6_reset_outputs", {tx_valid, busy}, 0);
        pq[0].push_back(8'h01);
        pq[2].push_back(8'h02);
        repeat (2) @(negedge clk);
        check("t6_ready_in_reset", req_ready, 0);
        never_ready = 1'b0;
        gnt_log.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        wait_drained("t6_drain", 200);
        check("t6_first_winner", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);
        check("t6_sent", uart_log.size(), 2);
        for (int k = 0; k < uart_log.size(); k++) begin
            check($sformatf("t6_byte%0d", k), uart_log[k], 8'(k + 1));
        end

        // Randomized traffic against the model
        rand_mode = 1'b1;
        base = m_hs + m_drops;
        pushed = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                q = int'($urandom_range(0, NR - 1));
                if (pq[q].size() < 3) begin
                    pq[q].push_back(8'($urandom));
                    pushed++;
                end
            end
        end
        wait_drained("rand_drain", 4000);
        rand_mode = 1'b0;
        check("rand_all_retired", m_hs + m_drops - base, pushed);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
